// File: rtl/clg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clg_ctrl_pkg
// Shared definitions for the digit-serial CLG adder controller: FSM state
// encoding, nibble width and the nibble step-count helper.
// Related configuration macro: CLG_SUB_EN (used by clg_serial_add_ctrl).
// ---------------------------------------------------------------------------
package clg_ctrl_pkg;

    localparam int unsigned NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble steps needed to cover an operand of the given width.
    function automatic int unsigned step_count(input int unsigned width);
        return width / NIB;
    endfunction

endpackage

// File: rtl/fourbits_CLGadder.sv
// ---------------------------------------------------------------------------
// fourbits_CLGadder
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a    in  4  operand A nibble
//   b    in  4  operand B nibble
//   cin  in  1  carry in
//   sum  out 4  nibble sum (combinational)
//   cout out 1  carry out of bit 3 (combinational)
// ---------------------------------------------------------------------------
module fourbits_CLGadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is computed directly from generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/clg_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// clg_serial_add_ctrl
// Digit-serial WIDTH-bit adder: latches an operand pair, pushes one nibble
// per cycle (LSB first) through a single 4-bit CLG slice, ripples the carry
// through a register and presents the assembled result via valid/ready.
// Optional macro CLG_SUB_EN adds a 'sub' input selecting a - b.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   in_valid  in  1      operand pair offered
//   in_ready  out 1      controller idle and able to accept
//   a, b      in  WIDTH  operands
//   cin       in  1      carry into bit 0
//   sub       in  1      (CLG_SUB_EN only) subtract b from a
//   out_valid out 1      result held for the consumer
//   out_ready in  1      consumer takes the result
//   sum       out WIDTH  result
//   cout      out 1      carry out of bit WIDTH-1 (no-borrow when subtracting)
//   busy      out 1      high while nibble steps are running
// ---------------------------------------------------------------------------
module clg_serial_add_ctrl
    import clg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLG_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSTEP = step_count(WIDTH);
    localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
        $error("clg_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic [SW-1:0]    step_q,      step_d;
    logic             carry_q,     carry_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
`ifdef CLG_SUB_EN
    logic             sub_q,       sub_d;
`endif

    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB-1:0]   slice_sum;
    logic             slice_cout;
    logic             carry_init;

    // Nibble selection for the current step; constant-index mux avoids a
    // variable part-select whose index width depends on WIDTH.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NSTEP; i++) begin
            if (step_q == SW'(i)) begin
                a_nib = a_q[i*NIB +: NIB];
                b_nib = b_q[i*NIB +: NIB];
            end
        end
`ifdef CLG_SUB_EN
        // Two's complement subtract: invert B here, carry starts at 1.
        if (sub_q) begin
            b_nib = ~b_nib;
        end
`endif
    end

    fourbits_CLGadder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Initial ripple carry for a newly accepted operation.
`ifdef CLG_SUB_EN
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign carry_init = cin;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        step_d      = step_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef CLG_SUB_EN
        sub_d       = sub_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = carry_init;
                    step_d     = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef CLG_SUB_EN
                    sub_d      = sub;
`endif
                end
            end

            RUN: begin
                for (int i = 0; i < NSTEP; i++) begin
                    if (step_q == SW'(i)) begin
                        sum_d[i*NIB +: NIB] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (step_q == SW'(NSTEP - 1)) begin
                    // Last nibble: publish carry-out and present the result.
                    cout_d      = slice_cout;
                    step_d      = '0;
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    step_d = SW'(step_q + SW'(1));
                end
            end

            DONE: begin
                // Only the consumer handshake acts here; new requests wait
                // for the following IDLE cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                step_d      = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            step_q      <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CLG_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            step_q      <= step_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef CLG_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
